// File: rtl/vga_fb_pkg.sv
// Shared types and VGA 640x480@60 timing constants for the framebuffer scanout block.
package vga_fb_pkg;

  typedef logic [2:0] colour_t;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  typedef enum logic {
    IDLE,
    CLEAR
  } fb_state_t;

endpackage

// File: rtl/vga_fb_scanout_if.sv
// Pixel-plot bus between drawing engines (master) and the framebuffer (slave).
// FB_CLEAR_EN adds the clear request and its fill colour.
interface vga_fb_scanout_if;
  import vga_fb_pkg::*;

  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  colour_t    VGA_COLOUR;
  logic       VGA_PLOT;
  logic       ready;
`ifdef FB_CLEAR_EN
  logic       clear;
  colour_t    clear_colour;
`endif

  modport master (
    output VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT,
`ifdef FB_CLEAR_EN
    output clear, clear_colour,
`endif
    input  ready
  );

  modport slave (
    input  VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT,
`ifdef FB_CLEAR_EN
    input  clear, clear_colour,
`endif
    output ready
  );

endinterface

// File: rtl/vga_fb_scanout_fb_ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
// A read and write to the same address on one edge returns the old contents.
module fb_ram_dp #(
  parameter int DEPTH  = 19200,
  parameter int DATA_W = 3,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer sink for the plot bus plus 640x480@60 VGA scanout with 4x pixel replication.
// Define FB_CLEAR_EN to add the hardware full-screen clear (clear / clear_colour).
module vga_fb_scanout #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_fb_scanout_if.slave  plot_bus,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_CLK
);
  import vga_fb_pkg::*;

  localparam int DEPTH  = FB_W * FB_H;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] H_ACT    = 10'(H_VIS);
  localparam logic [9:0] V_ACT    = 10'(V_VIS);

  function automatic logic [7:0] expand_bit(input logic b, input logic en);
    return (b && en) ? 8'hFF : 8'h00;
  endfunction

  logic              pix_en;
  logic [9:0]        h;
  logic [9:0]        v;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  colour_t           wdata;
  logic              plot_ok;
  logic [ADDR_W-1:0] plot_addr;

  logic              hs_p0, vs_p0, vld_p0;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic              hs_p1, vs_p1, vld_p1;
  colour_t           col_p1;

  // Write side: plots land immediately; off-screen coordinates are discarded.
  assign plot_ok   = plot_bus.VGA_PLOT && plot_bus.ready &&
                     (32'(plot_bus.VGA_X) < FB_W) && (32'(plot_bus.VGA_Y) < FB_H);
  assign plot_addr = ADDR_W'(32'(plot_bus.VGA_Y) * FB_W + 32'(plot_bus.VGA_X));

`ifdef FB_CLEAR_EN
  fb_state_t         state, state_nxt;
  logic [ADDR_W-1:0] clr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= (state == CLEAR) ? clr_addr + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt      = state;
    plot_bus.ready = 1'b1;
    we             = plot_ok;
    waddr          = plot_addr;
    wdata          = plot_bus.VGA_COLOUR;
    case (state)
      IDLE: begin
        if (plot_bus.clear) state_nxt = CLEAR;
      end
      CLEAR: begin
        plot_bus.ready = 1'b0;
        we             = 1'b1;
        waddr          = clr_addr;
        wdata          = plot_bus.clear_colour;
        if (clr_addr == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign plot_bus.ready = 1'b1;
  assign we             = plot_ok;
  assign waddr          = plot_addr;
  assign wdata          = plot_bus.VGA_COLOUR;
`endif

  // Raster counters advance once per 25 MHz pixel tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en <= 1'b0;
      h      <= '0;
      v      <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  assign VGA_CLK = pix_en;

  // Stage p0: timing decode and framebuffer address from the raw counters.
  assign hs_p0      = (h >= HS_START) && (h < HS_END);
  assign vs_p0      = (v >= VS_START) && (v < VS_END);
  assign vld_p0     = (h < H_ACT) && (v < V_ACT);
  assign rd_addr_p0 = vld_p0 ?
                      ADDR_W'((32'(v) >> SCALE_LOG2) * FB_W + (32'(h) >> SCALE_LOG2)) : '0;

  // Stage p1: RAM read in flight; sync/valid delayed to stay aligned with it.
  fb_ram_dp #(
    .DEPTH  (DEPTH),
    .DATA_W ($bits(colour_t)),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (pix_en),
    .raddr (rd_addr_p0),
    .rdata (col_p1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (pix_en) begin
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      vld_p1 <= vld_p0;
    end
  end

  // Stage p2: pin register; colour blanked outside the visible area, syncs active-low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      VGA_R  <= 8'h00;
      VGA_G  <= 8'h00;
      VGA_B  <= 8'h00;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else if (pix_en) begin
      VGA_R  <= expand_bit(col_p1[2], vld_p1);
      VGA_G  <= expand_bit(col_p1[1], vld_p1);
      VGA_B  <= expand_bit(col_p1[0], vld_p1);
      VGA_HS <= ~hs_p1;
      VGA_VS <= ~vs_p1;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Self-checking bench for vga_fb_scanout: timeline model of the raster plus framebuffer model.
// Build with FB_CLEAR_EN defined to also exercise the hardware clear.
`timescale 1ns/1ps
module tb_vga_fb_scanout;
  import vga_fb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic VGA_HS, VGA_VS, VGA_CLK;

  vga_fb_scanout_if bus();

  vga_fb_scanout dut (
    .clk      (clk),
    .rst      (rst),
    .plot_bus (bus),
    .VGA_R    (VGA_R),
    .VGA_G    (VGA_G),
    .VGA_B    (VGA_B),
    .VGA_HS   (VGA_HS),
    .VGA_VS   (VGA_VS),
    .VGA_CLK  (VGA_CLK)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: edges since reset release, framebuffer contents, per-pixel fetch snapshot.
  int      n = 0;
  int      clr_cnt = 0;
  colour_t model_mem [FB_DEPTH];
  bit      known     [FB_DEPTH];
  colour_t ring_col  [4];
  bit      ring_known[4];

  initial begin
    for (int i = 0; i < FB_DEPTH; i++) known[i] = 1'b0;
    for (int i = 0; i < 4; i++) ring_known[i] = 1'b0;
  end

  // A pixel shown as raster index t is fetched from the framebuffer as it stood just
  // before clock edge 2t+2 and appears on the pins after edge 2t+4.
  initial begin
    int t, mh, mv, a, x, y;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        n = 0;
        clr_cnt = 0;
      end else begin
        n++;
        if (n % 2 == 0) begin
          t  = n / 2 - 1;
          mh = t % 800;
          mv = (t / 800) % 525;
          if (mh < 640 && mv < 480) begin
            a = (mv / 4) * 160 + mh / 4;
            ring_col[t % 4]   = model_mem[a];
            ring_known[t % 4] = known[a];
          end
        end
        if (clr_cnt > 0) begin
          clr_cnt--;
`ifdef FB_CLEAR_EN
          if (clr_cnt == 0)
            for (int i = 0; i < FB_DEPTH; i++) begin
              model_mem[i] = bus.clear_colour;
              known[i]     = 1'b1;
            end
`endif
        end else begin
          x = int'(bus.VGA_X);
          y = int'(bus.VGA_Y);
          if (bus.VGA_PLOT && x < 160 && y < 120) begin
            model_mem[y * 160 + x] = bus.VGA_COLOUR;
            known[y * 160 + x]     = 1'b1;
          end
`ifdef FB_CLEAR_EN
          if (bus.clear) begin
            clr_cnt = FB_DEPTH;
            for (int i = 0; i < FB_DEPTH; i++) known[i] = 1'b0;
          end
`endif
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    int t, ch, cv;
    colour_t c;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_R", VGA_R, 0);
        check("rst_G", VGA_G, 0);
        check("rst_B", VGA_B, 0);
        check("rst_HS", VGA_HS, 1);
        check("rst_VS", VGA_VS, 1);
        check("rst_CLK", VGA_CLK, 0);
        check("rst_ready", bus.ready, 1);
      end else begin
        t = n / 2 - 2;
        check("vga_clk", VGA_CLK, n % 2);
        check("ready", bus.ready, (clr_cnt == 0));
        if (t < 0) begin
          check("early_RGB", {VGA_R, VGA_G, VGA_B}, 0);
          check("early_HS", VGA_HS, 1);
          check("early_VS", VGA_VS, 1);
        end else begin
          ch = t % 800;
          cv = (t / 800) % 525;
          check("hs", VGA_HS, !(ch >= 656 && ch <= 751));
          check("vs", VGA_VS, !(cv >= 490 && cv <= 491));
          if (!(ch < 640 && cv < 480)) begin
            check("blank_RGB", {VGA_R, VGA_G, VGA_B}, 0);
          end else if (ring_known[t % 4]) begin
            c = ring_col[t % 4];
            check("pix_R", VGA_R, {8{c[2]}});
            check("pix_G", VGA_G, {8{c[1]}});
            check("pix_B", VGA_B, {8{c[0]}});
          end
        end
      end
    end
  end

  task automatic plot_px(input int x, input int y, input colour_t c);
    bus.VGA_X      = 8'(x);
    bus.VGA_Y      = 7'(y);
    bus.VGA_COLOUR = c;
    bus.VGA_PLOT   = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic circle(input int cx, input int cy, input int r, input colour_t c);
    int x, y, d;
    x = r; y = 0; d = 1 - r;
    while (x >= y) begin
      plot_px(cx + x, cy + y, c); plot_px(cx - x, cy + y, c);
      plot_px(cx + x, cy - y, c); plot_px(cx - x, cy - y, c);
      plot_px(cx + y, cy + x, c); plot_px(cx - y, cy + x, c);
      plot_px(cx + y, cy - x, c); plot_px(cx - y, cy - x, c);
      y++;
      if (d < 0) d += 2 * y + 1;
      else begin
        x--;
        d += 2 * (y - x) + 1;
      end
    end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, fall1, fall2, lowcnt, cnt;
    bus.VGA_X = '0; bus.VGA_Y = '0; bus.VGA_COLOUR = '0; bus.VGA_PLOT = 1'b0;
`ifdef FB_CLEAR_EN
    bus.clear = 1'b0; bus.clear_colour = 3'b000;
`endif
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Fill the screen while timing the first hsync pulses from reset release.
    fork
      begin
        for (int y = 0; y < 120; y++)
          for (int x = 0; x < 160; x++)
            plot_px(x, y, 3'b000);
        plot_px(0, 0, 3'b010);
        plot_px(1, 0, 3'b111);
        plot_px(2, 0, 3'b001);
        plot_px(5, 1, 3'b110);
        plot_px(159, 119, 3'b100);
        plot_px(160, 5, 3'b111);
        plot_px(3, 120, 3'b111);
        circle(80, 60, 40, 3'b010);
        bus.VGA_PLOT = 1'b0;
      end
      begin
        e = 0;
        while (VGA_HS !== 1'b0 && e < 3000) begin
          @(posedge clk); #1; e++;
        end
        check("hs_first_fall_edge", e, 1316);
        fall1 = e;
        lowcnt = 1;
        while (e < 4000) begin
          @(posedge clk); #1; e++;
          if (VGA_HS === 1'b1) break;
          lowcnt++;
        end
        check("hs_low_clks", lowcnt, 192);
        while (VGA_HS !== 1'b0 && e < 6000) begin
          @(posedge clk); #1; e++;
        end
        fall2 = e;
        check("hs_period_clks", fall2 - fall1, 1600);
      end
    join

    // Reset mid-frame: raster restarts, framebuffer keeps its contents.
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    wait_edges(12);
    check("lit_x1y0_RGB", {VGA_R, VGA_G, VGA_B}, 24'hFFFFFF);
    wait_edges(22 - 12);
    check("lit_x2y0_RGB", {VGA_R, VGA_G, VGA_B}, 24'h0000FF);
    wait_edges(1326 - 22);
    check("lit_hblank_RGB", {VGA_R, VGA_G, VGA_B}, 24'h000000);
    check("lit_hblank_HS", VGA_HS, 0);
    wait_edges(1404 - 1326);
    check("lit_hblank2_RGB", {VGA_R, VGA_G, VGA_B}, 24'h000000);
    wait_edges(1608 - 1404);
    check("lit_x0y0_RGB", {VGA_R, VGA_G, VGA_B}, 24'h00FF00);
    check("lit_x0y0_VS", VGA_VS, 1);
    wait_edges(6446 - 1608);
    check("lit_x5y1_RGB", {VGA_R, VGA_G, VGA_B}, 24'hFFFF00);
    wait_edges(12800 - 6446);

    check("mem_0_0", dut.u_ram.mem[0], 3'b010);
    check("mem_159_119", dut.u_ram.mem[19199], 3'b100);
    check("mem_drop_x160", dut.u_ram.mem[960], 3'b000);
    check("mem_drop_y120", dut.u_ram.mem[3], 3'b000);
    check("mem_circle_e", dut.u_ram.mem[60 * 160 + 120], 3'b010);
    check("mem_circle_n", dut.u_ram.mem[20 * 160 + 80], 3'b010);
    check("mem_centre", dut.u_ram.mem[60 * 160 + 80], 3'b000);
    for (int i = 0; i < FB_DEPTH; i++)
      check("mem_model", dut.u_ram.mem[i], model_mem[i]);

`ifdef FB_CLEAR_EN
    @(negedge clk);
    bus.clear = 1'b1; bus.clear_colour = 3'b001;
    @(negedge clk);
    bus.clear = 1'b0;
    cnt = 0;
    while (bus.ready === 1'b0 && cnt < 20000) begin
      cnt++;
      if (cnt == 5000) begin
        bus.VGA_X = 8'd10; bus.VGA_Y = 7'd10; bus.VGA_COLOUR = 3'b111; bus.VGA_PLOT = 1'b1;
      end else begin
        bus.VGA_PLOT = 1'b0;
      end
      bus.clear = (cnt == 8000);
      @(negedge clk);
    end
    bus.VGA_PLOT = 1'b0;
    bus.clear = 1'b0;
    check("clear_busy_clks", cnt, 19200);
    repeat (2) @(negedge clk);
    check("clear_plot_ignored", dut.u_ram.mem[10 * 160 + 10], 3'b001);
    for (int i = 0; i < FB_DEPTH; i++)
      check("clear_cell", dut.u_ram.mem[i], 3'b001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
